inner_product_seq: RTL and testbench
====================================

INNER_PRODUCT_SEQ -- requirements
Module: inner_product_seq

Interface
REQ-001 The block SHALL take parameter data_width, default 2, giving the width of each operand element and of the result.
REQ-002 The block SHALL take parameter num_elems, default 2, giving the number of element pairs per vector (num_elems >= 1).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous abort; discards the partial sum and any held result.
REQ-006 in_valid  input  1  element pair on in_a/in_b is valid.
REQ-007 in_ready  output  1  block accepts an element pair this cycle.
REQ-008 in_a  input  data_width  unsigned element of vector A.
REQ-009 in_b  input  data_width  unsigned element of vector B.
REQ-010 out_valid  output  1  outp holds a completed inner product.
REQ-011 out_ready  input  1  downstream accepts outp this cycle.
REQ-012 outp  output  data_width  inner product of the last num_elems accepted pairs.

Function
REQ-013 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 An input handshake SHALL occur when in_valid && in_ready at a rising edge; only then SHALL acc += in_a*in_b and elem_idx increment.
REQ-015 The accumulator SHALL be 2*data_width + clog2(num_elems) bits wide (minimum 2*data_width+1), so it never overflows internally.
REQ-016 On the handshake with elem_idx == num_elems-1, the block SHALL register the final sum into outp, reset elem_idx to 0, and enter HOLD on the next cycle (latency: outp valid one cycle after the last pair).
REQ-017 In HOLD, outp SHALL remain stable until an output handshake (out_valid && out_ready); then the block SHALL clear acc and return to ACCUM on the next cycle.
REQ-018 With out_ready tied high and in_valid continuous, one result SHALL appear every num_elems+1 cycles.
REQ-019 in_a/in_b values while in_valid=0 or in HOLD SHALL have no effect.
REQ-020 clear=1 at a rising edge SHALL force ACCUM, acc=0, elem_idx=0, out_valid=0, and SHALL take priority over a simultaneous input or output handshake (the pair and/or result is dropped).
REQ-021 outp SHALL be the accumulator value reduced to data_width per REQ-025/REQ-026.

Reset
REQ-022 While rst_n=0, state SHALL be ACCUM, acc=0, elem_idx=0, outp=0, out_valid=0, in_ready=0.
REQ-023 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts; assertion mid-vector or mid-HOLD SHALL discard all partial and held data immediately.

Configuration
REQ-024 Macro INNER_PRODUCT_SAT_EN SHALL select the result-reduction mode.
REQ-025 Without INNER_PRODUCT_SAT_EN, outp SHALL be the sum modulo 2**data_width (low bits), matching the combinational inner product.
REQ-026 With INNER_PRODUCT_SAT_EN, outp SHALL be min(sum, 2**data_width-1).

Structure
REQ-027 A shared package inner_product_pkg SHALL hold the state typedef (ACCUM, HOLD) and the accumulator-width function.
REQ-028 A sub-module inner_product_mac SHALL implement the registered multiply-accumulate (acc, clear/load control); inner_product_seq SHALL hold the FSM, counter and output register.

Verification (data_width=2, num_elems=2)
REQ-029 Pairs (1,3),(2,1), out_ready=1 -> sum 5; outp=1 without macro, outp=3 with macro; out_valid high one cycle after second pair.
REQ-030 Pairs (1,1),(1,1) -> outp=2 in both modes; next vector accepted the cycle after the output handshake.
REQ-031 Backpressure: result held with out_ready=0 for 3 cycles -> outp and out_valid stable, in_ready=0, incoming pairs ignored.
REQ-032 clear asserted after first pair (3,3) then pairs (1,2),(1,1) -> outp=3 (first pair discarded).
REQ-033 rst_n pulsed low in HOLD -> out_valid=0, outp=0 immediately; next vector (2,2),(0,3) -> outp=0 wrap / 3 saturated.
REQ-034 Continuous in_valid, out_ready=1 for 4 vectors -> results every 3 cycles, no pair lost or duplicated.

Source files
------------

// File: rtl/inner_product_pkg.sv
// Shared types and sizing helpers for the sequential inner-product block.
package inner_product_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Accumulator width that can hold num_elems full-width products without overflow.
  function automatic int acc_width(input int dw, input int ne);
    int w;
    w = 2 * dw + $clog2(ne);
    if (w < 2 * dw + 1) w = 2 * dw + 1;
    return w;
  endfunction

endpackage

// File: rtl/inner_product_mac.sv
// Registered multiply-accumulate with clear/load control and result reduction.
// INNER_PRODUCT_SAT_EN selects saturating reduction; default keeps the low bits.
module inner_product_mac #(
  parameter int data_width = 2,
  parameter int acc_w      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] res
);

  logic [acc_w-1:0] acc;
  logic [acc_w-1:0] sum;

  // sum includes the pair being accepted so the final result can be captured on that edge
  assign sum = acc + acc_w'(a) * acc_w'(b);

`ifdef INNER_PRODUCT_SAT_EN
  localparam logic [acc_w-1:0] sat_max = {{(acc_w-data_width){1'b0}}, {data_width{1'b1}}};
  assign res = (sum > sat_max) ? {data_width{1'b1}} : sum[data_width-1:0];
`else
  assign res = sum[data_width-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/inner_product_seq.sv
// Sequential inner product: accepts num_elems element pairs, then holds the result.
// INNER_PRODUCT_SAT_EN makes outp saturate instead of wrapping.
module inner_product_seq
  import inner_product_pkg::*;
#(
  parameter int data_width = 2,
  parameter int num_elems  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_a,
  input  logic [data_width-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] outp
);

  localparam int acc_w = acc_width(data_width, num_elems);
  localparam int idx_w = (num_elems > 1) ? $clog2(num_elems) : 1;

  state_t                  state;
  logic [idx_w-1:0]        idx;
  logic [data_width-1:0]   res;
  logic                    hs_in, hs_out, last;

  assign hs_in  = in_valid && in_ready;
  assign hs_out = out_valid && out_ready;
  assign last   = (idx == idx_w'(num_elems - 1));

  inner_product_mac #(.data_width(data_width), .acc_w(acc_w)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear || hs_out),
    .en    (hs_in && !clear),
    .a     (in_a),
    .b     (in_b),
    .res   (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      idx       <= '0;
      outp      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      idx       <= '0;
      outp      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (hs_in) begin
            if (last) begin
              outp      <= res;
              idx       <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (hs_out) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_product_seq.sv
// Bench for inner_product_seq (data_width=2, num_elems=2): table vectors,
// hand-written corner sequences and randomized traffic against a scoreboard.
module tb_inner_product_seq;

  localparam int DW = 2;
  localparam int NE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] outp;

  inner_product_seq #(.data_width(DW), .num_elems(NE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  // Reference model: pairs accumulate into a pending sum; every NE pairs yields a result.
  int exp_q[$];
  int pend_sum = 0;
  int pend_cnt = 0;
  bit cont_chk = 1'b0;
  int last_cyc = -1;
  bit rnd_on   = 1'b0;

  function automatic int reduce(input int s);
    int mx;
    mx = (1 << DW) - 1;
`ifdef INNER_PRODUCT_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s % (mx + 1);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input int a, input int b);
    pend_sum += a * b;
    pend_cnt++;
    if (pend_cnt == NE) begin
      exp_q.push_back(reduce(pend_sum));
      pend_sum = 0;
      pend_cnt = 0;
    end
  endtask

  task automatic model_clear();
    pend_sum = 0;
    pend_cnt = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'd0, 32'd1);
      else check("sb_outp", 32'(outp), 32'(exp_q.pop_front()));
      if (cont_chk) begin
        if (last_cyc >= 0) check("spacing", 32'(cyc - last_cyc), 32'(NE + 1));
        last_cyc = cyc;
      end
    end
  end

  // Leaves in_valid high so consecutive calls form a continuous stream.
  task automatic send_pair(input int a, input int b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = DW'(a);
    in_b = DW'(b);
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (!clear) model_accept(a, b);
    end
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int a0, b0, a1, b1;
    int exp_wrap, exp_sat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 3, 2, 1, 1, 3};
    tbl[1] = '{1, 1, 1, 1, 2, 2};
    tbl[2] = '{3, 3, 3, 3, 2, 3};
    tbl[3] = '{0, 0, 0, 0, 0, 0};
    tbl[4] = '{2, 1, 0, 3, 2, 2};
    tbl[5] = '{3, 1, 0, 2, 3, 3};

    // reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outp", 32'(outp), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready_up", 32'(in_ready), 32'd1);

    // table vectors, out_ready high
    for (int i = 0; i < 6; i++) begin
      int e;
`ifdef INNER_PRODUCT_SAT_EN
      e = tbl[i].exp_sat;
`else
      e = tbl[i].exp_wrap;
`endif
      send_pair(tbl[i].a0, tbl[i].b0);
      send_pair(tbl[i].a1, tbl[i].b1);
      in_valid = 1'b0;
      check("tbl_latency_valid", 32'(out_valid), 32'd1);
      check("tbl_outp", 32'(outp), 32'(e));
      check("tbl_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("tbl_post_valid", 32'(out_valid), 32'd0);
      check("tbl_post_in_ready", 32'(in_ready), 32'd1);
    end

    // backpressure: held result stable, incoming pairs ignored
    out_ready = 1'b0;
    send_pair(2, 1);
    send_pair(1, 1);
    in_valid = 1'b1;
    in_a = 2'd3;
    in_b = 2'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_outp", 32'(outp), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_pair(1, 1);
    send_pair(1, 1);
    in_valid = 1'b0;
    drain();

    // clear after the first pair discards it
    send_pair(3, 3);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    send_pair(1, 2);
    send_pair(1, 1);
    in_valid = 1'b0;
    check("clr_outp", 32'(outp), 32'd3);
    drain();

    // clear while holding drops the result
    out_ready = 1'b0;
    send_pair(1, 1);
    send_pair(1, 1);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    check("clr_hold_valid", 32'(out_valid), 32'd0);
    check("clr_hold_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // clear beats a simultaneous input handshake
    in_valid = 1'b1;
    in_a = 2'd3;
    in_b = 2'd3;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    model_clear();
    send_pair(1, 1);
    send_pair(0, 0);
    in_valid = 1'b0;
    check("clr_hs_outp", 32'(outp), 32'd1);
    drain();

    // asynchronous reset while holding
    out_ready = 1'b0;
    send_pair(1, 1);
    send_pair(1, 1);
    in_valid = 1'b0;
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_outp", 32'(outp), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready_up", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send_pair(2, 2);
    send_pair(0, 3);
    in_valid = 1'b0;
    check("arst_next_outp", 32'(outp), 32'(reduce(4)));
    drain();

    // continuous stream, results every NE+1 cycles
    cont_chk = 1'b1;
    last_cyc = -1;
    for (int i = 0; i < 4 * NE; i++) send_pair($urandom_range(0, 3), $urandom_range(0, 3));
    in_valid = 1'b0;
    drain();
    cont_chk = 1'b0;
    check("cont_count_done", 32'(pend_cnt), 32'd0);

    // randomized gaps and backpressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send_pair($urandom_range(0, 3), $urandom_range(0, 3));
        end
        in_valid = 1'b0;
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
